led_hex_display: RTL and testbench
==================================

LED_HEX_DISPLAY -- requirements
Module: led_hex_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12500: clk cycles each digit is lit (50 MHz gives a 4 kHz digit rate and 1 kHz frame rate).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, 50 MHz, rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port value, input, 8 bits: the byte to display, fed by the upstream 1 Hz counter's led bus.
REQ-005 SHALL have port an, output, 4 bits: active-low digit anodes; an[0] is the rightmost digit.
REQ-006 SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-007 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-008 SHALL register all outputs; no combinational path from value to any output.

Function
REQ-009 SHALL run a scan counter from 0 to SCAN_DIV-1; at terminal count the counter SHALL wrap to 0 and the digit index SHALL advance 0->1->2->3->0.
REQ-010 SHALL drive an as the registered one-hot-low of the digit index (index 0 -> 4'b1110, index 3 -> 4'b0111), updated one cycle after each index change.
REQ-011 SHALL drive seg as the registered hex glyph of the selected digit nibble, aligned on the same edge as an.
REQ-012 SHALL use these glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-013 SHALL for a blank digit drive its an bit high (off) for that slot; seg is don't-care there but SHALL be 7'b1111111.
REQ-014 SHALL hold dp at 1 at all times.
REQ-015 SHALL hold a display register (4 nibbles plus 4 blank flags) that the scan reads; updates to it take effect on the next scan slot with no partial-glyph glitch.

Reset
REQ-016 SHALL, while reset_n=0, drive an=4'b1111, seg=7'b1111111, dp=1, scan counter=0, digit index=0, display register=0 with all digits blank, converter FSM=IDLE.
REQ-017 SHALL, on the first rising clk after reset_n deasserts, present an=4'b1110.
REQ-018 SHALL, when reset asserts mid-conversion or mid-scan, abandon all state immediately; no partial result reaches the display register.

Configuration
REQ-019 SHALL use macro BCD_DISPLAY_EN to select the display mode.
REQ-020 SHALL, without BCD_DISPLAY_EN, register value into the display register every cycle (latency 1 cycle): digit0=value[3:0], digit1=value[7:4], digits 2 and 3 blank, no leading-zero blanking.
REQ-021 SHALL, with BCD_DISPLAY_EN, convert value to decimal 000-255 using a sequential shift-add-3 converter with FSM states IDLE, SHIFT and DONE.
REQ-022 SHALL, in IDLE, transition to SHIFT when value differs from the last converted source; value is latched on that transition.
REQ-023 SHALL, in SHIFT, perform exactly 8 shift iterations (one per cycle, add-3 applied to each BCD nibble >=5 before the shift), then go to DONE.
REQ-024 SHALL, in DONE, write digits to the display register for one cycle and return to IDLE; latency from value change to display register update is 10 cycles.
REQ-025 SHALL ignore value changes during SHIFT/DONE; the mismatch is detected in IDLE and reconverted, so the final value is always displayed.
REQ-026 SHALL, in BCD mode, always blank digit3, blank hundreds when 0, blank tens when hundreds and tens are both 0, and always show units.

Verification (SCAN_DIV=4 for simulation)
REQ-027 SHALL cover: reset_n low -> an=1111, seg=1111111, dp=1; release -> an=1110 next edge, then 1101, 1011, 0111 at 4-cycle spacing, then back to 1110.
REQ-028 SHALL cover: hex build, value=8'h5F -> digit0 seg=0001110, digit1 seg=0010010, an[2] and an[3] never low.
REQ-029 SHALL cover: BCD build, value=8'd255 -> after 10 cycles digits show 2,5,5 (0100100, 0010010, 0010010), an[3] never low.
REQ-030 SHALL cover: BCD build, value=8'd7 -> only an[0] ever low, seg=1111000; value=8'd0 -> units shows 1000000.
REQ-031 SHALL cover: BCD build, value 12->200 changed on cycle 3 of SHIFT -> 12 displayed first, then 200 within a further 10 cycles, with no other value ever shown.
REQ-032 SHALL cover: reset_n pulsed low during SHIFT -> display fully blank; after release value=8'd42 -> 4,2 shown, hundreds blank.

Source files
------------

// File: rtl/led_hex_display.sv
// Four-digit multiplexed seven-segment driver with a registered display register.
// Define BCD_DISPLAY_EN to show value as decimal 0-255; otherwise it is shown as two hex digits.
module led_hex_display #(
  parameter int SCAN_DIV = 12500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] value,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [15:0]   nib_q, nib_d;
  logic [3:0]    blank_q, blank_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q;
  logic [3:0]    sel_nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

`ifdef BCD_DISPLAY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  conv_state_e state_q;
  logic [7:0]  src_q;
  logic        src_valid_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [2:0]  step_q;
  logic [3:0]  ten_adj, uni_adj;
  logic [3:0]  hun, ten;

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Hundreds never exceeds 2 for an 8-bit input, so only tens and units need add-3.
  assign ten_adj = add3(bcd_q[7:4]);
  assign uni_adj = add3(bcd_q[3:0]);
  assign hun     = bcd_q[11:8];
  assign ten     = bcd_q[7:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      src_q       <= 8'h00;
      src_valid_q <= 1'b0;
      bin_q       <= 8'h00;
      bcd_q       <= 12'h000;
      step_q      <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!src_valid_q || (value != src_q)) begin
            src_q       <= value;
            src_valid_q <= 1'b1;
            bin_q       <= value;
            bcd_q       <= 12'h000;
            step_q      <= 3'd0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q  <= {bcd_q[10:8], ten_adj, uni_adj, bin_q[7]};
          bin_q  <= {bin_q[6:0], 1'b0};
          step_q <= step_q + 3'd1;
          if (step_q == 3'd7) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    nib_d   = nib_q;
    blank_d = blank_q;
    if (state_q == DONE) begin
      nib_d   = {4'h0, bcd_q};
      blank_d = {1'b1, hun == 4'd0, (hun == 4'd0) && (ten == 4'd0), 1'b0};
    end
  end
`else
  // Reload only on a difference; the register contents are the same either way.
  always_comb begin
    nib_d   = nib_q;
    blank_d = blank_q;
    if ({nib_q, blank_q} != {8'h00, value, 4'b1100}) begin
      nib_d   = {8'h00, value};
      blank_d = 4'b1100;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_q   <= 16'h0000;
      blank_q <= 4'hF;
    end else begin
      nib_q   <= nib_d;
      blank_q <= blank_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The scan samples the display register's incoming contents so a write and its glyph land on one edge.
  assign sel_nib = nib_d[{idx_q, 2'b00} +: 4];

  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    if (!blank_d[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = glyph(sel_nib);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_led_hex_display.sv
// Directed bench for led_hex_display at SCAN_DIV=4; BCD_DISPLAY_EN selects the decimal scenarios.
module tb_led_hex_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] value = 8'h00;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_k   = 0;
  int disp_val = -1;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  led_hex_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (value),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected an/seg for scan slot given the value on show (-1 means all blank).
  task automatic expect_out(input int v, input int slot, output logic [3:0] an_e, output logic [6:0] seg_e);
    logic [3:0] d;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    if (v >= 0) begin
`ifdef BCD_DISPLAY_EN
      int h, t, u;
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      case (slot)
        0: begin d = 4'(u); an_e = 4'b1110; seg_e = glyph_tab[d]; end
        1: if (h != 0 || t != 0) begin d = 4'(t); an_e = 4'b1101; seg_e = glyph_tab[d]; end
        2: if (h != 0) begin d = 4'(h); an_e = 4'b1011; seg_e = glyph_tab[d]; end
        default: ;
      endcase
`else
      case (slot)
        0: begin d = 4'(v % 16); an_e = 4'b1110; seg_e = glyph_tab[d]; end
        1: begin d = 4'((v / 16) % 16); an_e = 4'b1101; seg_e = glyph_tab[d]; end
        default: ;
      endcase
`endif
    end
  endtask

  task automatic step();
    logic [3:0] an_e;
    logic [6:0] seg_e;
    int slot;
    @(posedge clk);
    #1;
    edge_k++;
    slot = ((edge_k - 1) / SCAN_DIV) % 4;
    expect_out(disp_val, slot, an_e, seg_e);
    check($sformatf("an k%0d v%0d", edge_k, disp_val), 32'(an), 32'(an_e));
    check($sformatf("seg k%0d v%0d", edge_k, disp_val), 32'(seg), 32'(seg_e));
    check($sformatf("dp k%0d", edge_k), 32'(dp), 32'd1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply(input logic [7:0] v);
    @(negedge clk);
    value = v;
    $display("apply value=%0d (0x%02h) at edge %0d", v, v, edge_k);
  endtask

  task automatic check_blank(input string tag);
    check({tag, " an"}, 32'(an), 32'hF);
    check({tag, " seg"}, 32'(seg), 32'h7F);
    check({tag, " dp"}, 32'(dp), 32'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    edge_k = 0;
    $display("release reset with value=%0d", value);
  endtask

  task automatic pulse_reset(input logic [7:0] v_after);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_blank("async reset");
    value = v_after;
    repeat (2) @(posedge clk);
    #1;
    check_blank("held reset");
  endtask

  initial begin
`ifdef BCD_DISPLAY_EN
    value = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    check_blank("reset");
    release_reset();
    disp_val = -1;
    steps(9);
    disp_val = 255;
    steps(16);

    apply(8'd7);
    steps(9);
    disp_val = 7;
    steps(16);

    apply(8'd0);
    steps(9);
    disp_val = 0;
    steps(16);

    apply(8'd12);
    steps(3);
    apply(8'd200);
    steps(6);
    disp_val = 12;
    steps(10);
    disp_val = 200;
    steps(16);

    apply(8'd99);
    steps(4);
    pulse_reset(8'd42);
    release_reset();
    disp_val = -1;
    steps(9);
    disp_val = 42;
    steps(16);
`else
    value = 8'h5F;
    repeat (3) @(posedge clk);
    #1;
    check_blank("reset");
    release_reset();
    disp_val = 8'h5F;
    steps(17);

    apply(8'hA3);
    disp_val = 8'hA3;
    steps(8);

    apply(8'h00);
    disp_val = 8'h00;
    steps(8);

    apply(8'hC7);
    disp_val = 8'hC7;
    steps(6);

    pulse_reset(8'h42);
    release_reset();
    disp_val = 8'h42;
    steps(16);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
